mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data stages onto one shared, registered memory port.
// Define ARB_TIMEOUT_EN to abandon a busy access after 255 cycles without mem_ack and set bus_err.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        if_abort,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BUSY  = 2'd1,
        IF_BUSY = 2'd2
    } ArbState;

    ArbState     state;
    ArbState     nextState;
    logic        ifOk;
    logic        dOk;
    logic        abortFlag;
    logic        issueData;
    logic        issueFetch;
    logic        accessDone;
    logic        timeout;
    logic [31:0] respData;

    assign stall    = (if_req && !ifOk) || (d_req && !dOk);
    assign respData = mem_ack ? mem_rdata : 32'h0000_0000;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] toCount;

    // The 255th busy cycle without an acknowledge ends the access.
    assign timeout = (state != IDLE) && !mem_ack && (toCount == 8'd254);

    always_ff @(posedge clk) begin
        if (!rst) begin
            toCount <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE || accessDone) begin
                toCount <= 8'd0;
            end else begin
                toCount <= toCount + 8'd1;
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Data wins simultaneous requests; a completed requester is not reissued until its ok flag clears.
    always_comb begin
        nextState  = state;
        issueData  = 1'b0;
        issueFetch = 1'b0;
        accessDone = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !dOk) begin
                    nextState = D_BUSY;
                    issueData = 1'b1;
                end else if (if_req && !ifOk) begin
                    nextState  = IF_BUSY;
                    issueFetch = 1'b1;
                end
            end
            D_BUSY, IF_BUSY: begin
                if (mem_ack || timeout) begin
                    nextState  = IDLE;
                    accessDone = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            ifOk      <= 1'b0;
            dOk       <= 1'b0;
            if_rdata  <= 32'h0000_0000;
            d_rdata   <= 32'h0000_0000;
            abortFlag <= 1'b0;
        end else begin
            if (!stall) begin
                ifOk <= 1'b0;
                dOk  <= 1'b0;
            end
            if (if_abort && ifOk) begin
                ifOk <= 1'b0;
            end

            if (issueData) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (issueFetch) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                abortFlag <= 1'b0;
            end

            // A fetch redirected while in flight still completes, but its result is thrown away.
            if (accessDone) begin
                mem_req   <= 1'b0;
                abortFlag <= 1'b0;
                if (state == D_BUSY) begin
                    dOk <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= respData;
                    end
                end else if (!abortFlag && !if_abort) begin
                    ifOk     <= 1'b1;
                    if_rdata <= respData;
                end
            end else if (state == IF_BUSY && if_abort) begin
                abortFlag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, fetch, priority, store, abort, timeout scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_abort = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    int          nIssued;
    int          reqAge;
    int          ackDelay;
    int          holdErr;
    int          firstFree;
    logic [31:0] issAddr [8];
    logic        issWe [8];
    logic [31:0] issWdata [8];
    int          issCycle [8];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_abort(if_abort),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic clearLog();
        nIssued   = 0;
        reqAge    = 0;
        holdErr   = 0;
        firstFree = -1;
        for (int i = 0; i < 8; i++) begin
            issAddr[i]  = 32'hXXXX_0000;
            issWe[i]    = 1'bx;
            issWdata[i] = 32'h0;
            issCycle[i] = -1;
        end
    endtask

    // Memory model: logs each new access, acks after ackDelay cycles, returns ~address.
    task automatic memRespond(input int c);
        if (mem_req) begin
            if (reqAge == 0) begin
                if (nIssued < 8) begin
                    issAddr[nIssued]  = mem_addr;
                    issWe[nIssued]    = mem_we;
                    issWdata[nIssued] = mem_wdata;
                    issCycle[nIssued] = c;
                end
                nIssued++;
            end else if (nIssued > 0 && nIssued <= 8 && mem_addr !== issAddr[nIssued-1]) begin
                holdErr++;
            end
            mem_ack   = (reqAge == ackDelay);
            mem_rdata = ~mem_addr;
            reqAge++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            reqAge    = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %0h, expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %0h, expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h, expected 0", mem_wdata); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_rdata: got %h, expected 0", if_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_rdata: got %h, expected 0", d_rdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_idle: got %0h, expected 0", stall); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %0h, expected 0", bus_err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        int stallCnt;
        stallCnt = 0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_after_reset: got %0h, expected 1", stall); end
        for (int c = 0; c < 6; c++) begin
            mem_ack   = (c == 3);
            mem_rdata = (c == 3) ? 32'h2008_0005 : 32'h0;
            #1;
            if (stall) stallCnt++;
            if (c == 1) begin
                checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_req: got %0h, expected 1", mem_req); end
                checks++; if (mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h, expected 00000040", mem_addr); end
                checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mem_we: got %0h, expected 0", mem_we); end
            end
            if (c == 4) begin
                checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("[TB] FAIL fetch_if_rdata: got %h, expected 20080005", if_rdata); end
                checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_req_drop: got %0h, expected 0", mem_req); end
                if_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++; if (stallCnt !== 4) begin errors++; $display("[TB] FAIL fetch_stall_cycles: got %0d, expected 4", stallCnt); end
    endtask

    task automatic test_simultaneous();
        clearLog();
        ackDelay = 1;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0004;
        for (int c = 0; c < 10; c++) begin
            memRespond(c);
            #1;
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                checks++; if (d_rdata !== 32'hEFFF_FFFB) begin errors++; $display("[TB] FAIL simul_d_rdata: got %h, expected effffffb", d_rdata); end
                checks++; if (if_rdata !== 32'hFFFF_FEFF) begin errors++; $display("[TB] FAIL simul_if_rdata: got %h, expected fffffeff", if_rdata); end
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++; if (nIssued !== 2) begin errors++; $display("[TB] FAIL simul_count: got %0d, expected 2", nIssued); end
        checks++; if (issAddr[0] !== 32'h1000_0004) begin errors++; $display("[TB] FAIL simul_first_addr: got %h, expected 10000004", issAddr[0]); end
        checks++; if (issAddr[1] !== 32'h0000_0100) begin errors++; $display("[TB] FAIL simul_second_addr: got %h, expected 00000100", issAddr[1]); end
        checks++; if (issCycle[1] !== 4) begin errors++; $display("[TB] FAIL simul_gap: got cycle %0d, expected 4", issCycle[1]); end
        checks++; if (firstFree !== 6) begin errors++; $display("[TB] FAIL simul_stall_release: got cycle %0d, expected 6", firstFree); end
    endtask

    task automatic test_store();
        int storeCnt;
        clearLog();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        for (int c = 0; c < 14; c++) begin
            ackDelay = (c < 3) ? 1 : 5;
            memRespond(c);
            #1;
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        storeCnt = 0;
        for (int i = 0; i < 8; i++) if (i < nIssued && issWe[i] === 1'b1) storeCnt++;
        checks++; if (storeCnt !== 1) begin errors++; $display("[TB] FAIL store_count: got %0d, expected 1", storeCnt); end
        checks++; if (nIssued !== 2) begin errors++; $display("[TB] FAIL store_total: got %0d, expected 2", nIssued); end
        checks++; if (issAddr[0] !== 32'h10 || issWdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_addr_data: got %h/%h, expected 00000010/deadbeef", issAddr[0], issWdata[0]); end
        checks++; if (issWe[1] !== 1'b0 || issAddr[1] !== 32'h200) begin errors++; $display("[TB] FAIL store_then_fetch: got we %0h addr %h, expected we 0 addr 00000200", issWe[1], issAddr[1]); end
        checks++; if (firstFree !== 10) begin errors++; $display("[TB] FAIL store_stall_release: got cycle %0d, expected 10", firstFree); end
        checks++; if (holdErr !== 0) begin errors++; $display("[TB] FAIL store_addr_hold: got %0d changes, expected 0", holdErr); end
    endtask

    task automatic test_abort();
        clearLog();
        ackDelay = 3;
        if_req = 1'b1; if_addr = 32'h0000_0044;
        for (int c = 0; c < 14; c++) begin
            if_abort = (c == 2);
            if (c == 2) if_addr = 32'h0000_0080;
            memRespond(c);
            #1;
            if (c == 5) begin
                checks++; if (if_rdata !== 32'hFFFF_FDFF) begin errors++; $display("[TB] FAIL abort_discard: got %h, expected fffffdff", if_rdata); end
                checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL abort_stall_held: got %0h, expected 1", stall); end
            end
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                if_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++; if (nIssued !== 2) begin errors++; $display("[TB] FAIL abort_count: got %0d, expected 2", nIssued); end
        checks++; if (issAddr[0] !== 32'h44 || issAddr[1] !== 32'h80) begin errors++; $display("[TB] FAIL abort_addrs: got %h,%h, expected 00000044,00000080", issAddr[0], issAddr[1]); end
        checks++; if (if_rdata !== 32'hFFFF_FF7F) begin errors++; $display("[TB] FAIL abort_redirect_data: got %h, expected ffffff7f", if_rdata); end
        checks++; if (firstFree !== 10) begin errors++; $display("[TB] FAIL abort_stall_release: got cycle %0d, expected 10", firstFree); end
    endtask

    task automatic test_abort_ok();
        clearLog();
        ackDelay = 1;
        if_req = 1'b1; if_addr = 32'h0000_0300;
        for (int c = 0; c < 13; c++) begin
            if (c == 2) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400; end
            if_abort = (c == 3);
            if (c == 3) if_addr = 32'h0000_0340;
            memRespond(c);
            #1;
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++; if (nIssued !== 3) begin errors++; $display("[TB] FAIL abortok_count: got %0d, expected 3", nIssued); end
        checks++; if (issAddr[1] !== 32'h400 || issAddr[2] !== 32'h340) begin errors++; $display("[TB] FAIL abortok_addrs: got %h,%h, expected 00000400,00000340", issAddr[1], issAddr[2]); end
        checks++; if (if_rdata !== 32'hFFFF_FCBF) begin errors++; $display("[TB] FAIL abortok_if_rdata: got %h, expected fffffcbf", if_rdata); end
        checks++; if (d_rdata !== 32'hFFFF_FBFF) begin errors++; $display("[TB] FAIL abortok_d_rdata: got %h, expected fffffbff", d_rdata); end
        checks++; if (firstFree !== 9) begin errors++; $display("[TB] FAIL abortok_stall_release: got cycle %0d, expected 9", firstFree); end
    endtask

    task automatic test_reset_mid();
        clearLog();
        ackDelay = -1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            memRespond(c);
            #1;
            if (c == 2) begin
                checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy: got req %0h we %0h, expected 1 1", mem_req, mem_we); end
                rst = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_mem_req: got %0h, expected 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall: got %0h, expected 0", stall); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_mem_regs: got %0h/%h/%h, expected 0/0/0", mem_we, mem_addr, mem_wdata); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_rdata: got %h/%h, expected 0/0", if_rdata, d_rdata); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_bus_err: got %0h, expected 0", bus_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL idle_ack_ignored: got %h/%h, expected 0/0", d_rdata, if_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_ack_req: got %0h, expected 0", mem_req); end
        @(negedge clk);
        clearLog();
        ackDelay = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        for (int c = 0; c < 8; c++) begin
            memRespond(c);
            #1;
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                d_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++; if (nIssued !== 1 || issAddr[0] !== 32'h600) begin errors++; $display("[TB] FAIL idle_load_issue: got %0d at %h, expected 1 at 00000600", nIssued, issAddr[0]); end
        checks++; if (d_rdata !== 32'hFFFF_F9FF) begin errors++; $display("[TB] FAIL idle_load_data: got %h, expected fffff9ff", d_rdata); end
        checks++; if (firstFree !== 3) begin errors++; $display("[TB] FAIL idle_load_release: got cycle %0d, expected 3", firstFree); end
    endtask

    task automatic test_timeout();
        int reqHigh;
        clearLog();
        ackDelay = -1;
        reqHigh = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
        for (int c = 0; c < 300; c++) begin
            memRespond(c);
            #1;
            if (mem_req) reqHigh++;
            if (firstFree < 0 && !stall) begin
                firstFree = c;
                checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rdata: got %h, expected 0", d_rdata); end
                d_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        #1;
`ifdef ARB_TIMEOUT_EN
        checks++; if (reqHigh !== 255) begin errors++; $display("[TB] FAIL timeout_busy_cycles: got %0d, expected 255", reqHigh); end
        checks++; if (firstFree !== 256) begin errors++; $display("[TB] FAIL timeout_stall_release: got cycle %0d, expected 256", firstFree); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_bus_err: got %0h, expected 1", bus_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout_mem_req: got %0h, expected 0", mem_req); end
`else
        checks++; if (reqHigh !== 299) begin errors++; $display("[TB] FAIL wait_busy_cycles: got %0d, expected 299", reqHigh); end
        checks++; if (firstFree !== -1) begin errors++; $display("[TB] FAIL wait_stall_held: got cycle %0d, expected -1", firstFree); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL wait_bus_err: got %0h, expected 0", bus_err); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_mem_req: got %0h, expected 1", mem_req); end
`endif
    endtask

    initial begin
        $display("[TB] mem_arbiter directed test start");
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_abort();
        test_abort_ok();
        test_reset_mid();
        test_ack_idle();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
